tl_inflight_monitor: RTL and testbench
======================================

Name: tl_inflight_monitor

Overview:
- Parametrised, synthesizable TileLink-UL/UH protocol checker for one A/D channel pair.
- Tracks every in-flight source ID and counts burst beats on both channels.
- Checks request/response correspondence and runs a response watchdog.
- Successor to the fixed-width monitor bound into queue testbenches: widths and size limits are generic, and it adds source tracking, burst checking and a timeout that the old block does not have.
- Bound passively onto any TL link in testbench or FPGA debug builds; drives no link signals.

Parameters:
- SOURCE_BITS, 6, width of a_source/d_source; tracking table has 2^SOURCE_BITS entries.
- ADDR_BITS, 32, width of a_address.
- BEAT_BYTES, 4, data bus bytes (power of two); log2 is LGB.
- SIZE_BITS, 4, width of a_size/d_size.
- MAX_SIZE, 6, largest legal log2 transfer size.
- TIMEOUT, 1024, watchdog cycles; 0 disables the watchdog.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- a_valid, a_ready  in  1  A handshake.
- a_opcode  in  3  A opcode.
- a_size  in  SIZE_BITS  A log2 size.
- a_source  in  SOURCE_BITS  A source ID.
- a_address  in  ADDR_BITS  A address.
- d_valid, d_ready  in  1  D handshake.
- d_opcode  in  3  D opcode.
- d_param  in  2  D param.
- d_size  in  SIZE_BITS  D log2 size.
- d_source  in  SOURCE_BITS  D source ID.
- err_valid  out  1  one-cycle pulse, registered.
- err_code  out  4  error code; valid with err_valid.
- err_source  out  SOURCE_BITS  source ID of the offending beat.
- err_any  out  1  sticky OR of all errors.
- inflight  out  SOURCE_BITS+1  count of pending sources.

Behaviour:
- Reset is synchronous, active-high. It clears the pending table, both beat counters, the watchdog and all outputs (all outputs 0). A reset mid-burst discards the burst. Only clock and reset drive state.
- Fire definitions: afire = a_valid & a_ready; dfire = d_valid & d_ready. Nothing is sampled without fire.
- Beat count: beats(size) = (size > LGB) ? 2^(size-LGB) : 1.
  - A carries data for opcodes 0 (PutFull), 1 (PutPartial), 2 (Arith) and 3 (Logic).
  - D carries data for opcode 1 (AccessAckData).
  - Data-less messages are always 1 beat.
- Burst state, per channel: IDLE or BURST, plus a beat counter of width MAX_SIZE-LGB+1.
  - First beat latches opcode, size, source (and address on A).
  - The counter counts down. Last beat returns to IDLE.
  - A 1-beat message stays in IDLE.
- Table entry per source: pending bit, expected D opcode (2 bits), size.
  - Set on the first A beat. Cleared on the last D beat.
  - Expected D opcode: Put → 0 (AccessAck); Get(4)/Arith/Logic → 1 (AccessAckData); Intent(5) → 2 (HintAck).
- Same-cycle interactions:
  - A last D beat frees its source in that cycle, so an A first beat reusing it in the same cycle is legal.
  - A D beat whose source's A first beat fires in the same cycle is legal. The checker uses the bypassed A fields.
- inflight = number of pending bits set. Updated the cycle after fire; +1, -1 or net 0 in the same cycle. It cannot wrap: the maximum is 2^SOURCE_BITS.
- Error codes, checked on fire:
  - 1: A opcode 6/7, or a_size > MAX_SIZE.
  - 2: A first beat on a pending source.
  - 3: A opcode/size/source/address changed mid-burst.
  - 4: A address not aligned to 2^a_size on the first beat.
  - 5: D source not pending.
  - 6: D opcode ≠ expected.
  - 7: d_size ≠ recorded size.
  - 8: D opcode/size/source changed mid-burst.
  - 9: watchdog expired.
  - 10: d_param ≠ 0.
- Error reporting:
  - If several errors occur in one cycle, the lowest code is reported; all set err_any.
  - err_valid/err_code/err_source are registered, 1-cycle latency.
  - After a code 2 or 5 error the table is still updated normally: a re-set stays set; a D on a non-pending source has no effect.
- Watchdog: counts cycles while inflight ≠ 0 and no dfire occurs; cleared on any dfire or when inflight = 0.
  - At count = TIMEOUT it raises code 9 with err_source = 0. The counter restarts from 0 after firing.
  - Absent when TIMEOUT = 0.

Test Plan:
- BEAT_BYTES=4: Get src 3, size 2, addr 0x100 → inflight 1. Then AccessAckData src 3, size 2 → inflight 0 and no err_valid.
- PutFull src 5, size 4 (4 beats); a_address changes on beat 3 → err_valid with code 3, err_source 5, one cycle after that beat.
- A on src 7 twice with no D → code 2 on the second; inflight stays 1. A D on src 9 → code 5.
- Same cycle: last D beat for src 2 and a new Get src 2 → no error; inflight unchanged at 1.
- TIMEOUT=16: one Get outstanding, no D for 16 cycles → code 9 pulse; err_any stays 1 until reset asserted for one cycle, then every output reads 0.
- In one cycle, D AccessAck (opcode 0) for a Get src 1, d_size wrong and d_param = 1 → code 6 reported, err_any set.

Source files
------------

// File: rtl/tl_inflight_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tl_inflight_monitor
//  Purpose  : Passive TileLink-UL/UH A/D checker: source tracking, burst
//             beat checking, request/response matching and response watchdog.
//  Revision : 1.0  initial release
// ============================================================================
module tl_inflight_monitor #(
    parameter int SOURCE_BITS = 6,
    parameter int ADDR_BITS   = 32,
    parameter int BEAT_BYTES  = 4,
    parameter int SIZE_BITS   = 4,
    parameter int MAX_SIZE    = 6,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   a_valid,
    input  logic                   a_ready,
    input  logic [2:0]             a_opcode,
    input  logic [SIZE_BITS-1:0]   a_size,
    input  logic [SOURCE_BITS-1:0] a_source,
    input  logic [ADDR_BITS-1:0]   a_address,
    input  logic                   d_valid,
    input  logic                   d_ready,
    input  logic [2:0]             d_opcode,
    input  logic [1:0]             d_param,
    input  logic [SIZE_BITS-1:0]   d_size,
    input  logic [SOURCE_BITS-1:0] d_source,
    output logic                   err_valid,
    output logic [3:0]             err_code,
    output logic [SOURCE_BITS-1:0] err_source,
    output logic                   err_any,
    output logic [SOURCE_BITS:0]   inflight
);

    localparam int c_lgb     = $clog2(BEAT_BYTES);
    localparam int c_cnt_w   = MAX_SIZE - c_lgb + 1;
    localparam int c_entries = 1 << SOURCE_BITS;

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_burst = 1'b1;

    // Illegal sizes are treated as single-beat so the burst tracker never overflows.
    function automatic logic [c_cnt_w-1:0] f_beats(input logic [SIZE_BITS-1:0] size,
                                                   input logic has_data);
        logic [c_cnt_w-1:0] n;
        n = {{(c_cnt_w-1){1'b0}}, 1'b1};
        if (has_data && (size > SIZE_BITS'(c_lgb)) && (size <= SIZE_BITS'(MAX_SIZE)))
            n = n << (size - SIZE_BITS'(c_lgb));
        return n;
    endfunction

    function automatic logic [1:0] f_exp_d(input logic [2:0] op);
        logic [1:0] e;
        case (op)
            3'd0, 3'd1:       e = 2'd0;
            3'd2, 3'd3, 3'd4: e = 2'd1;
            3'd5:             e = 2'd2;
            default:          e = 2'd3;
        endcase
        return e;
    endfunction

    // Channel burst trackers
    logic [0:0]             r_a_state, w_a_state_nxt;
    logic [c_cnt_w-1:0]     r_a_cnt, w_a_cnt_nxt;
    logic [2:0]             r_a_opcode;
    logic [SIZE_BITS-1:0]   r_a_size;
    logic [SOURCE_BITS-1:0] r_a_source;
    logic [ADDR_BITS-1:0]   r_a_address;

    logic [0:0]             r_d_state, w_d_state_nxt;
    logic [c_cnt_w-1:0]     r_d_cnt, w_d_cnt_nxt;
    logic [2:0]             r_d_opcode;
    logic [SIZE_BITS-1:0]   r_d_size;
    logic [SOURCE_BITS-1:0] r_d_source;
    logic                   r_d_hit;

    // Source table
    logic [c_entries-1:0]   r_pend, w_pend_nxt;
    logic [1:0]             r_exp   [c_entries];
    logic [SIZE_BITS-1:0]   r_rsize [c_entries];
    logic [SOURCE_BITS:0]   r_inflight, w_cnt_nxt;

    logic                   r_err_valid, r_err_any;
    logic [3:0]             r_err_code, w_code;
    logic [SOURCE_BITS-1:0] r_err_source, w_src;

    logic                   w_afire, w_dfire, w_a_first, w_d_first;
    logic                   w_a_last, w_d_last, w_a_set, w_a_set_eff;
    logic                   w_bypass, w_d_hit, w_d_clr, w_wd_fire;
    logic [c_cnt_w-1:0]     w_a_beats, w_d_beats;
    logic [SOURCE_BITS-1:0] w_d_clr_src;
    logic [1:0]             w_x_exp;
    logic [SIZE_BITS-1:0]   w_x_size;
    logic [ADDR_BITS-1:0]   w_a_mask;
    logic [10:1]            w_err;

    assign w_afire   = a_valid & a_ready;
    assign w_dfire   = d_valid & d_ready;
    assign w_a_first = (r_a_state == c_st_idle);
    assign w_d_first = (r_d_state == c_st_idle);
    assign w_a_beats = f_beats(a_size, a_opcode <= 3'd3);
    assign w_d_beats = f_beats(d_size, d_opcode == 3'd1);
    assign w_a_last  = w_a_first ? (w_a_beats == c_cnt_w'(1)) : (r_a_cnt == c_cnt_w'(1));
    assign w_d_last  = w_d_first ? (w_d_beats == c_cnt_w'(1)) : (r_d_cnt == c_cnt_w'(1));
    assign w_a_set   = w_afire & w_a_first;

    // A response to a request issued this very cycle sees the A fields directly.
    assign w_bypass    = w_dfire & w_d_first & w_a_set & (a_source == d_source) & ~r_pend[d_source];
    assign w_d_hit     = w_d_first ? (r_pend[d_source] | w_bypass) : r_d_hit;
    assign w_x_exp     = w_bypass ? f_exp_d(a_opcode) : r_exp[d_source];
    assign w_x_size    = w_bypass ? a_size : r_rsize[d_source];
    assign w_d_clr_src = w_d_first ? d_source : r_d_source;
    assign w_d_clr     = w_dfire & w_d_last & w_d_hit;
    assign w_a_set_eff = w_a_set & ~(w_bypass & w_d_last);
    assign w_a_mask    = ~({ADDR_BITS{1'b1}} << a_size);

    assign w_err[1]  = w_afire & ((a_opcode >= 3'd6) | (a_size > SIZE_BITS'(MAX_SIZE)));
    assign w_err[2]  = w_a_set & r_pend[a_source] & ~(w_d_clr & (w_d_clr_src == a_source));
    assign w_err[3]  = w_afire & ~w_a_first &
                       ((a_opcode != r_a_opcode) | (a_size != r_a_size) |
                        (a_source != r_a_source) | (a_address != r_a_address));
    assign w_err[4]  = w_a_set & (|(a_address & w_a_mask));
    assign w_err[5]  = w_dfire & w_d_first & ~w_d_hit;
    assign w_err[6]  = w_dfire & w_d_first & w_d_hit & (d_opcode != {1'b0, w_x_exp});
    assign w_err[7]  = w_dfire & w_d_first & w_d_hit & (d_size != w_x_size);
    assign w_err[8]  = w_dfire & ~w_d_first &
                       ((d_opcode != r_d_opcode) | (d_size != r_d_size) | (d_source != r_d_source));
    assign w_err[9]  = w_wd_fire;
    assign w_err[10] = w_dfire & (d_param != 2'd0);

    always_comb begin
        w_code = 4'd0;
        w_src  = {SOURCE_BITS{1'b0}};
        for (int i = 10; i >= 1; i--) begin
            if (w_err[i]) begin
                w_code = 4'(i);
                w_src  = (i <= 4) ? a_source : ((i == 9) ? {SOURCE_BITS{1'b0}} : d_source);
            end
        end
    end

    always_comb begin
        w_a_state_nxt = r_a_state;
        w_a_cnt_nxt   = r_a_cnt;
        if (w_afire) begin
            if (w_a_first) begin
                if (!w_a_last) begin
                    w_a_state_nxt = c_st_burst;
                    w_a_cnt_nxt   = w_a_beats - c_cnt_w'(1);
                end
            end else if (w_a_last) begin
                w_a_state_nxt = c_st_idle;
            end else begin
                w_a_cnt_nxt = r_a_cnt - c_cnt_w'(1);
            end
        end
    end

    always_comb begin
        w_d_state_nxt = r_d_state;
        w_d_cnt_nxt   = r_d_cnt;
        if (w_dfire) begin
            if (w_d_first) begin
                if (!w_d_last) begin
                    w_d_state_nxt = c_st_burst;
                    w_d_cnt_nxt   = w_d_beats - c_cnt_w'(1);
                end
            end else if (w_d_last) begin
                w_d_state_nxt = c_st_idle;
            end else begin
                w_d_cnt_nxt = r_d_cnt - c_cnt_w'(1);
            end
        end
    end

    // Clear before set: a freed source may be reissued in the same cycle.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_d_clr)
            w_pend_nxt[w_d_clr_src] = 1'b0;
        if (w_a_set_eff)
            w_pend_nxt[a_source] = 1'b1;
        w_cnt_nxt = '0;
        for (int i = 0; i < c_entries; i++)
            w_cnt_nxt = w_cnt_nxt + {{SOURCE_BITS{1'b0}}, w_pend_nxt[i]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_a_state    <= c_st_idle;
            r_a_cnt      <= '0;
            r_a_opcode   <= '0;
            r_a_size     <= '0;
            r_a_source   <= '0;
            r_a_address  <= '0;
            r_d_state    <= c_st_idle;
            r_d_cnt      <= '0;
            r_d_opcode   <= '0;
            r_d_size     <= '0;
            r_d_source   <= '0;
            r_d_hit      <= 1'b0;
            r_pend       <= '0;
            r_inflight   <= '0;
            r_err_valid  <= 1'b0;
            r_err_code   <= 4'd0;
            r_err_source <= '0;
            r_err_any    <= 1'b0;
        end else begin
            r_a_state <= w_a_state_nxt;
            r_a_cnt   <= w_a_cnt_nxt;
            r_d_state <= w_d_state_nxt;
            r_d_cnt   <= w_d_cnt_nxt;
            if (w_a_set) begin
                r_a_opcode  <= a_opcode;
                r_a_size    <= a_size;
                r_a_source  <= a_source;
                r_a_address <= a_address;
            end
            if (w_dfire && w_d_first) begin
                r_d_opcode <= d_opcode;
                r_d_size   <= d_size;
                r_d_source <= d_source;
                r_d_hit    <= w_d_hit;
            end
            r_pend       <= w_pend_nxt;
            r_inflight   <= w_cnt_nxt;
            r_err_valid  <= |w_err;
            r_err_code   <= w_code;
            r_err_source <= w_src;
            r_err_any    <= r_err_any | (|w_err);
        end
    end

    always_ff @(posedge clock) begin
        if (w_a_set) begin
            r_exp[a_source]   <= f_exp_d(a_opcode);
            r_rsize[a_source] <= a_size;
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_wd
            localparam int c_wd_w = $clog2(TIMEOUT + 1);
            logic [c_wd_w-1:0] r_wd_cnt;

            assign w_wd_fire = ~w_dfire & (r_inflight != '0) &
                               (r_wd_cnt == c_wd_w'(TIMEOUT - 1));

            always_ff @(posedge clock) begin
                if (reset || w_dfire || (r_inflight == '0) || w_wd_fire)
                    r_wd_cnt <= '0;
                else
                    r_wd_cnt <= r_wd_cnt + c_wd_w'(1);
            end
        end else begin : g_no_wd
            assign w_wd_fire = 1'b0;
        end
    endgenerate

    assign err_valid  = r_err_valid;
    assign err_code   = r_err_code;
    assign err_source = r_err_source;
    assign err_any    = r_err_any;
    assign inflight   = r_inflight;

endmodule
`default_nettype wire

// File: tb/tb_tl_inflight_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tl_inflight_monitor
//  Purpose  : Directed and randomized checks of tl_inflight_monitor against a
//             transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tl_inflight_monitor;

    localparam int SB   = 6;
    localparam int LGB  = 2;
    localparam int MAXS = 6;
    localparam int TMO  = 16;
    localparam int NSRC = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid, a_ready, d_valid, d_ready;
    logic [2:0]  a_opcode, d_opcode;
    logic [3:0]  a_size, d_size;
    logic [SB-1:0] a_source, d_source;
    logic [31:0] a_address;
    logic [1:0]  d_param;
    logic        err_valid, err_any;
    logic [3:0]  err_code;
    logic [SB-1:0] err_source;
    logic [SB:0] inflight;

    tl_inflight_monitor #(
        .SOURCE_BITS(SB), .ADDR_BITS(32), .BEAT_BYTES(4),
        .SIZE_BITS(4), .MAX_SIZE(MAXS), .TIMEOUT(TMO)
    ) dut (
        .clock(clk), .reset(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
        .a_source(a_source), .a_address(a_address),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source),
        .err_valid(err_valid), .err_code(err_code), .err_source(err_source),
        .err_any(err_any), .inflight(inflight)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: outstanding requests per source and remaining beats per channel.
    int   m_a_rem, m_a_op, m_a_size, m_a_src;
    logic [31:0] m_a_addr;
    int   m_d_rem, m_d_op, m_d_size, m_d_src;
    bit   m_d_hit;
    bit   m_pend [NSRC];
    int   m_exp  [NSRC];
    int   m_rsize[NSRC];
    int   m_wd, m_inflight, m_best, m_bsrc;
    bit   e_valid, e_any;
    int   e_code, e_src;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nbeats(int size, bit data);
        if (!data || size > MAXS || size <= LGB) return 1;
        return 1 << (size - LGB);
    endfunction

    function automatic int exp_d(int op);
        if (op <= 1) return 0;
        if (op <= 4) return 1;
        if (op == 5) return 2;
        return 3;
    endfunction

    task automatic note(input int c, input int s);
        if (m_best == 0 || c < m_best) begin
            m_best = c;
            m_bsrc = s;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NSRC; i++) m_pend[i] = 0;
        m_a_rem = 0; m_d_rem = 0; m_wd = 0; m_inflight = 0;
        e_valid = 0; e_any = 0; e_code = 0; e_src = 0;
    endtask

    task automatic model_cycle();
        bit afire, dfire, a_first, a_set, bypass, d_last, d_hit;
        int clr_src, tot;
        afire = a_valid && a_ready;
        dfire = d_valid && d_ready;
        a_first = (m_a_rem == 0);
        a_set = afire && a_first;
        bypass = 0; d_last = 0; d_hit = 0; clr_src = 0;
        m_best = 0; m_bsrc = 0;
        if (dfire) begin
            if (m_d_rem == 0) begin
                int xop, xsize;
                bypass = a_set && (a_source == d_source) && !m_pend[d_source];
                d_hit  = m_pend[d_source] || bypass;
                xop    = bypass ? exp_d(int'(a_opcode)) : m_exp[d_source];
                xsize  = bypass ? int'(a_size) : m_rsize[d_source];
                if (!d_hit) note(5, d_source);
                else begin
                    if (d_opcode != xop) note(6, d_source);
                    if (d_size != xsize) note(7, d_source);
                end
                tot = nbeats(int'(d_size), d_opcode == 1);
                d_last = (tot == 1);
                m_d_rem = tot - 1;
                m_d_op = d_opcode; m_d_size = d_size; m_d_src = d_source; m_d_hit = d_hit;
                clr_src = d_source;
            end else begin
                if (d_opcode != m_d_op || d_size != m_d_size || d_source != m_d_src) note(8, d_source);
                d_hit = m_d_hit;
                clr_src = m_d_src;
                m_d_rem--;
                d_last = (m_d_rem == 0);
            end
            if (d_param != 0) note(10, d_source);
        end
        if (afire) begin
            if (a_opcode >= 6 || a_size > MAXS) note(1, a_source);
            if (a_first) begin
                if (m_pend[a_source] && !(dfire && d_last && d_hit && clr_src == a_source))
                    note(2, a_source);
                if ((longint'(a_address) % (64'd1 << a_size)) != 0) note(4, a_source);
                tot = nbeats(int'(a_size), a_opcode <= 3);
                m_a_rem = tot - 1;
                m_a_op = a_opcode; m_a_size = a_size; m_a_src = a_source; m_a_addr = a_address;
            end else begin
                if (a_opcode != m_a_op || a_size != m_a_size || a_source != m_a_src || a_address != m_a_addr)
                    note(3, a_source);
                m_a_rem--;
            end
        end
        if (dfire && d_last && d_hit) m_pend[clr_src] = 0;
        if (a_set && !(bypass && d_last)) begin
            m_pend[a_source]  = 1;
            m_exp[a_source]   = exp_d(int'(a_opcode));
            m_rsize[a_source] = a_size;
        end
        if (m_inflight != 0 && !dfire) begin
            m_wd++;
            if (m_wd == TMO) begin
                note(9, 0);
                m_wd = 0;
            end
        end else begin
            m_wd = 0;
        end
        m_inflight = 0;
        for (int i = 0; i < NSRC; i++) m_inflight += m_pend[i];
        e_valid = (m_best != 0);
        e_code  = m_best;
        e_src   = m_bsrc;
        e_any   = e_any | e_valid;
    endtask

    task automatic step();
        if (rst) model_reset();
        else model_cycle();
        @(posedge clk);
        #1;
        check_eq("inflight", 32'(inflight), m_inflight);
        check_eq("err_valid", 32'(err_valid), 32'(e_valid));
        check_eq("err_any", 32'(err_any), 32'(e_any));
        if (e_valid) begin
            check_eq("err_code", 32'(err_code), e_code);
            check_eq("err_source", 32'(err_source), e_src);
        end
    endtask

    task automatic idle();
        a_valid = 0; a_ready = 1; a_opcode = 0; a_size = 0; a_source = 0; a_address = 0;
        d_valid = 0; d_ready = 1; d_opcode = 0; d_param = 0; d_size = 0; d_source = 0;
    endtask

    task automatic drive_a(input int op, input int size, input int src, input logic [31:0] addr);
        a_valid = 1; a_opcode = 3'(op); a_size = 4'(size); a_source = SB'(src); a_address = addr;
    endtask

    task automatic drive_d(input int op, input int size, input int src, input int param);
        d_valid = 1; d_opcode = 3'(op); d_size = 4'(size); d_source = SB'(src); d_param = 2'(param);
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
        check_eq("rst_valid", 32'(err_valid), 0);
        check_eq("rst_code", 32'(err_code), 0);
        check_eq("rst_source", 32'(err_source), 0);
        check_eq("rst_any", 32'(err_any), 0);
        check_eq("rst_inflight", 32'(inflight), 0);
    endtask

    task automatic gen_cycle(input int cyc);
        int r, s;
        a_valid = ($urandom_range(0, 2) != 0);
        a_ready = ($urandom_range(0, 3) != 0);
        if (m_a_rem > 0) begin
            a_opcode = 3'(m_a_op); a_size = 4'(m_a_size); a_source = SB'(m_a_src); a_address = m_a_addr;
            r = $urandom_range(0, 39);
            if (r == 0) a_address = a_address ^ 32'h4;
            else if (r == 1) a_size = a_size ^ 4'h1;
        end else begin
            r = $urandom_range(0, 99);
            a_opcode = (r < 3) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
            a_size = ($urandom_range(0, 49) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
            a_source = SB'($urandom_range(0, 15));
            a_address = $urandom & ~((32'h1 << a_size) - 32'h1);
            if (a_size != 0 && $urandom_range(0, 39) == 0) a_address = a_address | 32'h1;
            if (m_pend[a_source] && $urandom_range(0, 9) != 0) a_valid = 0;
        end
        d_valid = 0; d_param = 0;
        d_ready = ($urandom_range(0, 3) != 0);
        d_opcode = 0; d_size = 0; d_source = 0;
        if (m_d_rem > 0) begin
            d_valid = ($urandom_range(0, 2) != 0);
            d_opcode = 3'(m_d_op); d_size = 4'(m_d_size); d_source = SB'(m_d_src);
            if ($urandom_range(0, 39) == 0) d_size = d_size ^ 4'h1;
        end else begin
            s = $urandom_range(0, 15);
            if (m_pend[s] && $urandom_range(0, 1) == 1) begin
                drive_d(m_exp[s], m_rsize[s], s, 0);
                r = $urandom_range(0, 99);
                if (r < 3) d_opcode = d_opcode ^ 3'h1;
                else if (r < 6) d_size = d_size ^ 4'h1;
                else if (r < 8) d_param = 2'd1;
            end else if (a_valid && a_ready && m_a_rem == 0 && !m_pend[a_source]
                         && $urandom_range(0, 9) == 0) begin
                d_ready = 1;
                drive_d(exp_d(int'(a_opcode)), int'(a_size), int'(a_source), 0);
            end else if ($urandom_range(0, 40) == 0) begin
                drive_d(1, 2, $urandom_range(0, 15), 0);
            end
        end
        if ((cyc % 300) < 24 && m_d_rem == 0) d_valid = 0;
        rst = ((cyc % 700) == 699);
    endtask

    initial begin
        idle();
        do_reset();

        // Get then matching AccessAckData
        drive_a(4, 2, 3, 32'h100);
        step();
        check_eq("get_inflight", 32'(inflight), 1);
        idle();
        drive_d(1, 2, 3, 0);
        step();
        check_eq("ack_inflight", 32'(inflight), 0);
        check_eq("ack_noerr", 32'(err_valid), 0);
        idle();
        step();

        // PutFull 4 beats, address changes on beat 3
        for (int b = 0; b < 4; b++) begin
            drive_a(0, 4, 5, (b == 2) ? 32'h44 : 32'h40);
            step();
            if (b == 2) begin
                check_eq("burst_valid", 32'(err_valid), 1);
                check_eq("burst_code", 32'(err_code), 3);
                check_eq("burst_src", 32'(err_source), 5);
            end
        end
        idle();
        step();
        check_eq("burst_after", 32'(err_valid), 0);
        do_reset();

        // Re-request on pending source, then response on unknown source
        drive_a(4, 2, 7, 32'h200);
        step();
        step();
        check_eq("dup_code", 32'(err_code), 2);
        check_eq("dup_inflight", 32'(inflight), 1);
        idle();
        drive_d(1, 2, 9, 0);
        step();
        check_eq("nopend_code", 32'(err_code), 5);
        check_eq("nopend_src", 32'(err_source), 9);
        do_reset();

        // Last D beat and reuse of the same source in one cycle
        drive_a(4, 2, 2, 32'h10);
        step();
        drive_d(1, 2, 2, 0);
        step();
        check_eq("reuse_noerr", 32'(err_valid), 0);
        check_eq("reuse_inflight", 32'(inflight), 1);
        do_reset();

        // Wrong opcode, size and param together: lowest code wins
        drive_a(4, 2, 1, 32'h0);
        step();
        idle();
        drive_d(0, 3, 1, 1);
        step();
        check_eq("multi_code", 32'(err_code), 6);
        check_eq("multi_any", 32'(err_any), 1);
        do_reset();

        // Watchdog
        drive_a(4, 2, 0, 32'h0);
        step();
        idle();
        for (int n = 1; n <= TMO; n++) begin
            step();
            if (n < TMO) check_eq("wd_quiet", 32'(err_valid), 0);
        end
        check_eq("wd_valid", 32'(err_valid), 1);
        check_eq("wd_code", 32'(err_code), 9);
        check_eq("wd_src", 32'(err_source), 0);
        step();
        check_eq("wd_pulse", 32'(err_valid), 0);
        check_eq("wd_sticky", 32'(err_any), 1);
        do_reset();

        // Randomized traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            gen_cycle(cyc);
            step();
            rst = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
